// File: rtl/sa_request_ctrl_pkg.sv
// Shared router types for the switch-allocation request controller.
// Port enumeration order is the encoding seen on route_i / out_port_o.
package sa_request_ctrl_pkg;
  localparam int in_Port_Cnt = 5;

  typedef enum logic [2:0] {LOCAL, NORTH, EAST, SOUTH, WEST} inout_Port;
  typedef enum logic {VC_IDLE, VC_ACTIVE} vc_state_t;
endpackage

// File: rtl/sa_request_ctrl_if.sv
// Controller <-> router datapath/allocator bundle.
// master drives flits/routes/credits/grants; slave is the controller.
interface sa_request_ctrl_if
  import sa_request_ctrl_pkg::*;
#(
  parameter int vc_Num    = 4,
  parameter int BUF_DEPTH = 4
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic      [in_Port_Cnt-1:0][vc_Num-1:0] flit_valid_i;
  logic      [in_Port_Cnt-1:0][vc_Num-1:0] flit_head_i;
  logic      [in_Port_Cnt-1:0][vc_Num-1:0] flit_tail_i;
  inout_Port [in_Port_Cnt-1:0][vc_Num-1:0] route_i;
  logic      [in_Port_Cnt-1:0]             credit_ret_i;
  logic      [in_Port_Cnt-1:0][vc_Num-1:0] grant_i;
  logic      [in_Port_Cnt-1:0][vc_Num-1:0] request_o;
  inout_Port [in_Port_Cnt-1:0][vc_Num-1:0] out_port_o;
  logic      [in_Port_Cnt-1:0][vc_Num-1:0] pop_o;
  logic      [in_Port_Cnt-1:0][CW-1:0]     credit_cnt_o;
  logic                                    err_o;

  modport master (
    output flit_valid_i, flit_head_i, flit_tail_i, route_i, credit_ret_i, grant_i,
    input  request_o, out_port_o, pop_o, credit_cnt_o, err_o
  );

  modport slave (
    input  flit_valid_i, flit_head_i, flit_tail_i, route_i, credit_ret_i, grant_i,
    output request_o, out_port_o, pop_o, credit_cnt_o, err_o
  );
endinterface

// File: rtl/sa_request_ctrl_credit_counter.sv
// Downstream credit counter for one output port; saturates at BUF_DEPTH
// and flags a return that would overflow it.
module sa_request_ctrl_credit_counter #(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          ovf
);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  logic [CW-1:0] cnt_q;

  assign cnt = cnt_q;
  assign ovf = inc && !dec && (cnt_q == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= FULL;
    end else if (inc && !dec) begin
      if (cnt_q != FULL) cnt_q <= cnt_q + CW'(1);
    end else if (dec && !inc) begin
      // requests are gated on nonzero credit, so the zero guard is defensive
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/sa_request_ctrl.sv
// Switch-allocation request controller: per-VC packet FSMs, per-output
// credit tracking, and grant consumption in front of the allocator.
module sa_request_ctrl
  import sa_request_ctrl_pkg::*;
#(
  parameter int vc_Num    = 4,
  parameter int BUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  sa_request_ctrl_if.slave   bus
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic      [in_Port_Cnt-1:0][vc_Num-1:0] request;
  logic      [in_Port_Cnt-1:0][vc_Num-1:0] legal;
  logic      [in_Port_Cnt-1:0][vc_Num-1:0] idle_bad;
  inout_Port [in_Port_Cnt-1:0][vc_Num-1:0] out_port;
  logic      [in_Port_Cnt-1:0][CW-1:0]     credit_cnt;
  logic      [in_Port_Cnt-1:0]             dec, multi, ovf;
  logic                                    err_q;

  for (genvar p = 0; p < in_Port_Cnt; p++) begin : g_port
    for (genvar v = 0; v < vc_Num; v++) begin : g_vc
      vc_state_t st_q, st_d;
      inout_Port op_q, op_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          st_q <= VC_IDLE;
          op_q <= LOCAL;
        end else begin
          st_q <= st_d;
          op_q <= op_d;
        end
      end

      always_comb begin
        st_d = st_q;
        op_d = op_q;
        case (st_q)
          VC_IDLE: begin
            if (bus.flit_valid_i[p][v] && bus.flit_head_i[p][v]) begin
              st_d = VC_ACTIVE;
              op_d = bus.route_i[p][v];
            end
          end
          VC_ACTIVE: begin
            if (legal[p][v] && bus.flit_tail_i[p][v]) st_d = VC_IDLE;
          end
          default: st_d = VC_IDLE;
        endcase
      end

      assign request[p][v]  = (st_q == VC_ACTIVE) && bus.flit_valid_i[p][v] &&
                              (credit_cnt[op_q] != '0);
      assign legal[p][v]    = bus.grant_i[p][v] && request[p][v];
      assign idle_bad[p][v] = (st_q == VC_IDLE) && bus.flit_valid_i[p][v] &&
                              !bus.flit_head_i[p][v];
      assign out_port[p][v] = op_q;
    end
  end

  // A second legal grant to the same output is a protocol error; debit once.
  always_comb begin
    dec   = '0;
    multi = '0;
    for (int o = 0; o < in_Port_Cnt; o++) begin
      for (int p = 0; p < in_Port_Cnt; p++) begin
        for (int v = 0; v < vc_Num; v++) begin
          if (legal[p][v] && (out_port[p][v] == inout_Port'(o))) begin
            if (dec[o]) multi[o] = 1'b1;
            dec[o] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar o = 0; o < in_Port_Cnt; o++) begin : g_cred
    sa_request_ctrl_credit_counter #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (bus.credit_ret_i[o]),
      .dec (dec[o]),
      .cnt (credit_cnt[o]),
      .ovf (ovf[o])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | (|idle_bad) | (|(bus.grant_i & ~request)) |
                      (|multi) | (|ovf);
  end

  assign bus.request_o    = request;
  assign bus.pop_o        = legal;
  assign bus.out_port_o   = out_port;
  assign bus.credit_cnt_o = credit_cnt;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_sa_request_ctrl.sv
// Directed bench for sa_request_ctrl: packet flow, credit gating,
// saturation, illegal grants and mid-packet reset.
module tb_sa_request_ctrl;
  import sa_request_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sa_request_ctrl_if #(.vc_Num(4), .BUF_DEPTH(4)) bus ();

  sa_request_ctrl #(.vc_Num(4), .BUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.flit_valid_i = '0;
    bus.flit_head_i  = '0;
    bus.flit_tail_i  = '0;
    bus.route_i      = '{default: LOCAL};
    bus.credit_ret_i = '0;
    bus.grant_i      = '0;
  endtask

  task automatic chk_all_credits(input string tag, input int exp);
    for (int o = 0; o < in_Port_Cnt; o++)
      chk(tag, 32'(bus.credit_cnt_o[o]), 32'(exp));
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // reset / idle state
    chk_all_credits("reset_credit", 4);
    chk("reset_req", 32'(bus.request_o), 32'd0);
    chk("reset_pop", 32'(bus.pop_o), 32'd0);
    chk("reset_err", 32'(bus.err_o), 32'd0);

    // single-flit packet NORTH vc1 -> EAST
    bus.flit_valid_i[NORTH][1] = 1'b1;
    bus.flit_head_i[NORTH][1]  = 1'b1;
    bus.flit_tail_i[NORTH][1]  = 1'b1;
    bus.route_i[NORTH][1]      = EAST;
    #1 chk("sf_req_idle", 32'(bus.request_o[NORTH][1]), 32'd0);
    step();
    chk("sf_outport", 32'(bus.out_port_o[NORTH][1]), 32'(EAST));
    chk("sf_req", 32'(bus.request_o[NORTH][1]), 32'd1);
    bus.grant_i[NORTH][1] = 1'b1;
    #1 chk("sf_pop", 32'(bus.pop_o[NORTH][1]), 32'd1);
    step();
    clear_inputs();
    #1;
    chk("sf_credit_east", 32'(bus.credit_cnt_o[EAST]), 32'd3);
    chk("sf_req_after", 32'(bus.request_o[NORTH][1]), 32'd0);

    // 5-flit packet LOCAL vc0 -> SOUTH, credits run out after 4 pops
    bus.flit_valid_i[LOCAL][0] = 1'b1;
    bus.flit_head_i[LOCAL][0]  = 1'b1;
    bus.route_i[LOCAL][0]      = SOUTH;
    step();
    bus.flit_head_i[LOCAL][0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.grant_i[LOCAL][0] = 1'b1;
      #1 chk("mf_pop", 32'(bus.pop_o[LOCAL][0]), 32'd1);
      step();
    end
    bus.grant_i[LOCAL][0]     = 1'b0;
    bus.flit_tail_i[LOCAL][0] = 1'b1;
    #1;
    chk("mf_credit_zero", 32'(bus.credit_cnt_o[SOUTH]), 32'd0);
    chk("mf_req_blocked", 32'(bus.request_o[LOCAL][0]), 32'd0);
    bus.credit_ret_i[SOUTH] = 1'b1;
    step();
    bus.credit_ret_i[SOUTH] = 1'b0;
    #1;
    chk("mf_credit_ret", 32'(bus.credit_cnt_o[SOUTH]), 32'd1);
    chk("mf_req_resume", 32'(bus.request_o[LOCAL][0]), 32'd1);
    bus.grant_i[LOCAL][0] = 1'b1;
    #1 chk("mf_tail_pop", 32'(bus.pop_o[LOCAL][0]), 32'd1);
    step();
    bus.grant_i[LOCAL][0]     = 1'b0;
    bus.flit_tail_i[LOCAL][0] = 1'b0;
    chk("mf_credit_end", 32'(bus.credit_cnt_o[SOUTH]), 32'd0);
    // a new head only latches if the VC went back to IDLE
    bus.flit_head_i[LOCAL][0] = 1'b1;
    bus.route_i[LOCAL][0]     = WEST;
    step();
    chk("mf_idle_relatch", 32'(bus.out_port_o[LOCAL][0]), 32'(WEST));

    // WEST: simultaneous grant + credit return, then saturation
    bus.flit_head_i[LOCAL][0] = 1'b0;
    bus.grant_i[LOCAL][0]     = 1'b1;
    step();
    step();
    chk("w_credit_two", 32'(bus.credit_cnt_o[WEST]), 32'd2);
    bus.credit_ret_i[WEST] = 1'b1;
    step();
    bus.credit_ret_i[WEST] = 1'b0;
    chk("w_inc_dec", 32'(bus.credit_cnt_o[WEST]), 32'd2);
    chk("w_err_clean", 32'(bus.err_o), 32'd0);
    bus.flit_tail_i[LOCAL][0] = 1'b1;
    step();
    clear_inputs();
    chk("w_credit_one", 32'(bus.credit_cnt_o[WEST]), 32'd1);
    bus.credit_ret_i[WEST] = 1'b1;
    step();
    step();
    step();
    chk("w_credit_full", 32'(bus.credit_cnt_o[WEST]), 32'd4);
    chk("w_err_before", 32'(bus.err_o), 32'd0);
    step();
    bus.credit_ret_i[WEST] = 1'b0;
    chk("w_saturate", 32'(bus.credit_cnt_o[WEST]), 32'd4);
    chk("w_err_ovf", 32'(bus.err_o), 32'd1);

    // grant without request
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_err_clear", 32'(bus.err_o), 32'd0);
    bus.grant_i[EAST][2] = 1'b1;
    #1 chk("ig_pop", 32'(bus.pop_o), 32'd0);
    step();
    bus.grant_i[EAST][2] = 1'b0;
    chk("ig_err", 32'(bus.err_o), 32'd1);
    chk_all_credits("ig_credit", 4);

    // reset with three packets in flight and counts at 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.flit_valid_i[NORTH][0] = 1'b1;
    bus.flit_valid_i[SOUTH][3] = 1'b1;
    bus.flit_valid_i[WEST][2]  = 1'b1;
    bus.flit_head_i[NORTH][0]  = 1'b1;
    bus.flit_head_i[SOUTH][3]  = 1'b1;
    bus.flit_head_i[WEST][2]   = 1'b1;
    bus.route_i[NORTH][0]      = EAST;
    bus.route_i[SOUTH][3]      = WEST;
    bus.route_i[WEST][2]       = NORTH;
    step();
    bus.flit_head_i = '0;
    bus.grant_i[NORTH][0] = 1'b1;
    bus.grant_i[SOUTH][3] = 1'b1;
    bus.grant_i[WEST][2]  = 1'b1;
    step();
    step();
    step();
    bus.grant_i = '0;
    chk("mr_east_one", 32'(bus.credit_cnt_o[EAST]), 32'd1);
    chk("mr_west_one", 32'(bus.credit_cnt_o[WEST]), 32'd1);
    chk("mr_north_one", 32'(bus.credit_cnt_o[NORTH]), 32'd1);
    chk("mr_err_clean", 32'(bus.err_o), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mr_req_clear", 32'(bus.request_o), 32'd0);
    chk_all_credits("mr_credit", 4);
    chk("mr_err", 32'(bus.err_o), 32'd0);
    chk("mr_outport", 32'(bus.out_port_o[NORTH][0]), 32'(LOCAL));
    clear_inputs();
    step();
    chk("mr_err_after", 32'(bus.err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
